// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking controller.
package parking_pkg;

  localparam int unsigned CAPACITY_DEF = 15;
  localparam int unsigned TIMEOUT_DEF  = 16;
  localparam int unsigned CNT_W_DEF    = 4;

  typedef enum logic [1:0] {
    G_IDLE    = 2'b00,
    G_OPEN    = 2'b01,
    G_CLOSING = 2'b10
  } gate_state_t;

endpackage

// File: rtl/parking_occ_cnt.sv
// Occupancy counter: saturating up/down count, full decode and sticky err.
module parking_occ_cnt
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY = CAPACITY_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_in,
  input  logic             car_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             err
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  if (CAPACITY < 1 || CAPACITY > 255 || CAPACITY >= (1 << CNT_W)) begin : g_bad_cap
    $error("parking_occ_cnt: CAPACITY out of range for CNT_W");
  end

  // Simultaneous in/out nets to zero and is never an error, even at the limits.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      case ({car_in, car_out})
        2'b10: if (count == CAP) err <= 1'b1; else count <= count + 1'b1;
        2'b01: if (count == '0)  err <= 1'b1; else count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign full = (count == CAP);

endmodule

// File: rtl/parking_ctrl.sv
// Parking lot entry gate controller with occupancy tracking.
// Optional gate auto-close enabled by defining PARKING_TIMEOUT_EN.
module parking_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY = CAPACITY_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             car_in,
  input  logic             car_out,
  output logic             gate_open,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             denied,
  output logic             err
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_tmo
    $error("parking_ctrl: TIMEOUT must be 1..255");
  end

  gate_state_t state_q, state_d;
  logic        expire;

  parking_occ_cnt #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occ (
    .clk     (clk),
    .reset   (reset),
    .car_in  (car_in),
    .car_out (car_out),
    .count   (count),
    .full    (full),
    .err     (err)
  );

`ifdef PARKING_TIMEOUT_EN
  logic [7:0] tmo_q;

  // Counts cycles spent in G_OPEN; zero on the first open cycle.
  always_ff @(posedge clk) begin
    if (reset || state_q != G_OPEN) tmo_q <= '0;
    else                            tmo_q <= tmo_q + 1'b1;
  end

  assign expire = (state_q == G_OPEN) && (tmo_q == 8'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= G_IDLE;
      denied  <= 1'b0;
    end else begin
      state_q <= state_d;
      denied  <= (state_q == G_IDLE) && entry_req && full;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      G_IDLE:    if (entry_req && !full) state_d = G_OPEN;
      // car_in wins over a simultaneous expiry; both lead to G_CLOSING.
      G_OPEN:    if (car_in || expire)   state_d = G_CLOSING;
      G_CLOSING: state_d = G_IDLE;
      default:   state_d = G_IDLE;
    endcase
  end

  assign gate_open = (state_q == G_OPEN);

endmodule
